iter_divider: RTL and testbench

//  Multi-cycle integer divider for the execute stage; the sequential counterpart of the combinational add/sub unit.

---
 rtl/div_pkg.sv | 18 +
 rtl/iter_divider_if.sv | 24 ++
 rtl/div_step.sv | 20 ++
 rtl/iter_divider.sv | 130 +++++++++++++
 tb/tb_iter_divider.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM encoding and counter sizing.
package div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Bits needed to count down from width-1 to 0.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/iter_divider_if.sv
// Request/response bundle between the execute stage (master) and the divider (slave).
interface iter_divider_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic             Signed;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             DivByZero;

    modport master (
        output Start, Signed, A, B,
        input  Busy, Done, Quotient, Remainder, DivByZero
    );

    modport slave (
        input  Start, Signed, A, B,
        output Busy, Done, Quotient, Remainder, DivByZero
    );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift in the next dividend bit, try to subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_dvd_msb,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_next_rem,
    output logic             o_q_bit
);
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    // The shifted remainder keeps its top bit: with unsigned divisors near 2^WIDTH
    // the partial remainder can have its MSB set, so the subtract is WIDTH+1 bits wide.
    assign w_shifted  = {i_rem, i_dvd_msb};
    assign w_trial    = w_shifted - {1'b0, i_divisor};
    assign o_q_bit    = ~w_trial[WIDTH];
    assign o_next_rem = o_q_bit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU (Quotient -> LO, Remainder -> HI).
// Optional build macro DIV_EARLY_TERM_EN: finish immediately when |A| < |B|.
module iter_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic          Clk,
    input logic          Rst_n,
    iter_divider_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_dbz;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot_o;
    logic [WIDTH-1:0] r_rem_o;
    logic             r_dbz_o;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_next_rem;
    logic             w_q_bit;
    logic             w_b_zero;
    logic             w_early;

    assign w_a_mag  = (bus.Signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign w_b_mag  = (bus.Signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    assign w_b_zero = (bus.B == '0);

`ifdef DIV_EARLY_TERM_EN
    assign w_early = !w_b_zero && (w_a_mag < w_b_mag);
`else
    assign w_early = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem      (r_rem),
        .i_dvd_msb  (r_dvd[WIDTH-1]),
        .i_divisor  (r_dvs),
        .o_next_rem (w_next_rem),
        .o_q_bit    (w_q_bit)
    );

    // r_dvd doubles as the quotient: dividend bits shift out the top while
    // quotient bits shift in at the bottom.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_dbz    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_quot_o <= '0;
            r_rem_o  <= '0;
            r_dbz_o  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.Start) begin
                        r_dvd   <= w_a_mag;
                        r_dvs   <= w_b_mag;
                        r_rem   <= '0;
                        r_cnt   <= CW'(WIDTH - 1);
                        r_q_neg <= bus.Signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                        r_r_neg <= bus.Signed & bus.A[WIDTH-1];
                        r_dbz   <= w_b_zero;
                        r_busy  <= 1'b1;
                        if (w_b_zero) begin
                            r_dvd   <= '1;
                            r_rem   <= bus.A;
                            r_state <= ST_DONE;
                        end else if (w_early) begin
                            r_dvd   <= '0;
                            r_rem   <= bus.A;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_rem <= w_next_rem;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    // Truncating division: remainder follows the dividend's sign.
                    if (r_q_neg) r_dvd <= -r_dvd;
                    if (r_r_neg) r_rem <= -r_rem;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_quot_o <= r_dvd;
                    r_rem_o  <= r_rem;
                    r_dbz_o  <= r_dbz;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.Busy      = r_busy;
    assign bus.Done      = r_done;
    assign bus.Quotient  = r_quot_o;
    assign bus.Remainder = r_rem_o;
    assign bus.DivByZero = r_dbz_o;
endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider at WIDTH=32; honours DIV_EARLY_TERM_EN when defined.
module tb_iter_divider;
    localparam int W = 32;
    localparam int FULL_LAT = W + 2;

    typedef struct {
        string       tag;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
        int          exp_cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   busy_run;
    exp_t sb[$];

    iter_divider_if #(.WIDTH(W)) bus ();

    iter_divider #(.WIDTH(W)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference results from native SV arithmetic (truncating division).
    function automatic exp_t model(input string tag, input bit sgn, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t        e;
        logic [31:0] ma;
        logic [31:0] mb;
        e.tag = tag;
        e.dbz = 1'b0;
        e.lat = FULL_LAT;
        e.exp_cyc = 0;
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            e.dbz = 1'b1;
            e.lat = 1;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.q = 32'h8000_0000;
                e.r = 32'd0;
            end else begin
                e.q = $signed(a) / $signed(b);
                e.r = $signed(a) % $signed(b);
            end
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
`ifdef DIV_EARLY_TERM_EN
        if (b != 32'd0 && ma < mb) begin
            e.q = 32'd0;
            e.r = a;
            e.lat = 1;
        end
`else
        if (ma == mb) e.lat = FULL_LAT;
`endif
        return e;
    endfunction

    // Called at a negedge; leaves one cycle later with Start low again.
    task automatic do_op(input string tag, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b);
        exp_t e;
        e = model(tag, sgn, a, b);
        e.exp_cyc = cyc + 1 + e.lat;
        sb.push_back(e);
        bus.Signed = sgn;
        bus.A = a;
        bus.B = b;
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = bus.Done;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = bus.Done;
        end
        check({tag, ".done_seen"}, 64'(seen), 64'd1);
    endtask

    // Compare each Done against the oldest expectation, including latency and Busy coverage.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (bus.Done) begin
                check("done_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.tag, ".q"},       64'(bus.Quotient),  64'(e.q));
                    check({e.tag, ".r"},       64'(bus.Remainder), 64'(e.r));
                    check({e.tag, ".dbz"},     64'(bus.DivByZero), 64'(e.dbz));
                    check({e.tag, ".latency"}, 64'(cyc),           64'(e.exp_cyc));
                    check({e.tag, ".busy"},    64'(busy_run),      64'(e.lat));
                end
            end
            busy_run = bus.Busy ? busy_run + 1 : 0;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"}, 64'(bus.Busy),      64'd0);
        check({tag, ".done"}, 64'(bus.Done),      64'd0);
        check({tag, ".q"},    64'(bus.Quotient),  64'd0);
        check({tag, ".r"},    64'(bus.Remainder), 64'd0);
        check({tag, ".dbz"},  64'(bus.DivByZero), 64'd0);
    endtask

    initial begin
        cyc = 0;
        n_checks = 0;
        n_fail = 0;
        busy_run = 0;
        rst_n = 1'b0;
        bus.Start = 1'b0;
        bus.Signed = 1'b0;
        bus.A = '0;
        bus.B = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        do_op("divu_100_7", 1'b0, 32'd100, 32'd7);
        wait_done("divu_100_7");
        // Back-to-back: next Start issued in the Done cycle.
        do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_m7_2");
        do_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_done("div_7_m2");
        do_op("div_by0", 1'b1, 32'h1234, 32'd0);
        wait_done("div_by0");
        do_op("divu_by0", 1'b0, 32'h1234, 32'd0);
        wait_done("divu_by0");
        do_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_min_m1");
        do_op("divu_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("divu_min_m1");
        do_op("divu_0_5", 1'b0, 32'd0, 32'd5);
        wait_done("divu_0_5");
        do_op("divu_5_9", 1'b0, 32'd5, 32'd9);
        wait_done("divu_5_9");
        do_op("divu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        wait_done("divu_max");

        // A Start pulse while busy must not disturb the running operation.
        do_op("divu_1000_3", 1'b0, 32'd1000, 32'd3);
        repeat (4) @(negedge clk);
        bus.A = 32'd77;
        bus.B = 32'd0;
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        wait_done("divu_1000_3");

        // Asynchronous reset in the middle of CALC discards the operation.
        do_op("div_aborted", 1'b1, 32'h7654_3210, 32'd13);
        repeat (9) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        sb.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        do_op("after_reset", 1'b0, 32'd100, 32'd7);
        wait_done("after_reset");

        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom >> (i * 4);
            do_op($sformatf("rand%0d", i), (i % 2) == 1, a, b);
            wait_done($sformatf("rand%0d", i));
        end

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
